// File: rtl/arbitro_rr4.sv
// rtl/arbitro_rr4.sv - round-robin pop arbiter draining four input FIFOs into one push stream
// Two-stage pipeline: pop -> FIFO read latency -> registered push.
module arbitro_rr4 #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [3:0]            fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data0,
  input  logic [DATA_WIDTH-1:0] fifo_data1,
  input  logic [DATA_WIDTH-1:0] fifo_data2,
  input  logic [DATA_WIDTH-1:0] fifo_data3,
  input  logic                  pausa,
  output logic [3:0]            pop,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  active,
  output logic [CNT_WIDTH-1:0]  word_count
);

  logic [1:0]            rr_ptr;
  logic [3:0]            hold;
  logic                  s1_vld;
  logic [1:0]            s1_sel;
  logic [3:0]            eligible;
  logic                  grant;
  logic [1:0]            grant_idx;
  logic [1:0]            cand;
  logic [DATA_WIDTH-1:0] sel_data;

  // The hold mask keeps a just-popped port out for one cycle, covering the
  // FIFO's late empty flag when its last word was taken.
  always_comb begin
    eligible  = ~fifo_empty & ~hold;
    grant     = 1'b0;
    grant_idx = rr_ptr;
    cand      = 2'd0;
    pop       = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!grant && eligible[cand]) begin
        grant     = 1'b1;
        grant_idx = cand;
      end
    end
    if (!reset_L || pausa) grant = 1'b0;
    if (grant) pop[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_data = fifo_data0;
    case (s1_sel)
      2'd0: sel_data = fifo_data0;
      2'd1: sel_data = fifo_data1;
      2'd2: sel_data = fifo_data2;
      2'd3: sel_data = fifo_data3;
      default: sel_data = fifo_data0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rr_ptr     <= 2'd3;
      hold       <= 4'b0000;
      s1_vld     <= 1'b0;
      s1_sel     <= 2'd0;
      push       <= 1'b0;
      data_out   <= '0;
      word_count <= '0;
    end else begin
      if (grant) begin
        rr_ptr <= grant_idx;
        hold   <= pop;
        s1_vld <= 1'b1;
        s1_sel <= grant_idx;
      end else begin
        hold   <= 4'b0000;
        s1_vld <= 1'b0;
      end
      push <= s1_vld;
      if (s1_vld) data_out <= sel_data;
      if (push) word_count <= word_count + CNT_WIDTH'(1);
    end
  end

  assign active = s1_vld | push;

endmodule

// File: tb/tb_arbitro_rr4.sv
// tb/tb_arbitro_rr4.sv - directed bench for arbitro_rr4 with registered-read input FIFO models
module tb_arbitro_rr4;

  logic       clk;
  logic       reset_L;
  logic [3:0] fifo_empty;
  logic [5:0] fd [4];
  logic       pausa;
  logic [3:0] pop;
  logic       push;
  logic [5:0] data_out;
  logic       active;
  logic [7:0] word_count;

  int checks   = 0;
  int failures = 0;

  logic [5:0] mem [4][128];
  int         rd [4];
  int         wr [4];

  arbitro_rr4 #(.DATA_WIDTH(6), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_L(reset_L), .fifo_empty(fifo_empty),
    .fifo_data0(fd[0]), .fifo_data1(fd[1]), .fifo_data2(fd[2]), .fifo_data3(fd[3]),
    .pausa(pausa), .pop(pop), .push(push), .data_out(data_out),
    .active(active), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic load(input int p, input logic [5:0] w);
    mem[p][wr[p]] = w;
    wr[p]++;
    fifo_empty[p] = 1'b0;
  endtask

  // FIFO model: data appears the cycle after pop, empty flag lags one cycle.
  task automatic tick();
    logic [3:0] p;
    p = pop;
    check("pop_onehot0", 32'($onehot0(p)), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i] = (wr[i] == rd[i]);
      if (p[i]) begin
        if (wr[i] == rd[i]) check("pop_on_empty", 0, 1);
        else begin
          fd[i] = mem[i][rd[i]];
          rd[i]++;
        end
      end
    end
    @(negedge clk);
  endtask

  logic [3:0] rot_pop  [12] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
  logic       rot_push [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  logic [5:0] rot_data [12] = '{6'h00, 6'h00, 6'h10, 6'h11, 6'h12, 6'h13, 6'h20, 6'h21, 6'h22, 6'h23, 6'h00, 6'h00};

  logic [3:0] sp_pop   [8] = '{4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0};
  logic       sp_push  [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
  logic [5:0] sp_data  [8] = '{6'h00, 6'h00, 6'h30, 6'h00, 6'h31, 6'h00, 6'h32, 6'h00};

  logic       bp_pausa [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
  logic [3:0] bp_pop   [8] = '{4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h4, 4'h8};
  logic       bp_push  [8] = '{0, 0, 1, 1, 0, 0, 0, 1};
  logic [5:0] bp_data  [8] = '{6'h00, 6'h00, 6'h18, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08};

  initial begin
    #100000;
    $display("FAIL timeout watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    reset_L    = 1'b0;
    pausa      = 1'b0;
    fifo_empty = 4'hF;
    for (int i = 0; i < 4; i++) begin
      fd[i] = 6'h00;
      rd[i] = 0;
      wr[i] = 0;
    end
    for (int i = 0; i < 4; i++) load(i, 6'(6'h10 + i));
    for (int i = 0; i < 4; i++) load(i, 6'(6'h20 + i));
    @(negedge clk);
    @(negedge clk);
    check("rst_pop", pop, 0);
    check("rst_push", push, 0);
    check("rst_data", data_out, 0);
    check("rst_wc", word_count, 0);
    check("rst_active", active, 0);

    reset_L = 1'b1;
    #1;
    check("first_grant", pop, 4'b0001);

    for (int c = 0; c < 12; c++) begin
      check("rot_pop", pop, rot_pop[c]);
      check("rot_push", push, rot_push[c]);
      if (rot_push[c]) check("rot_data", data_out, rot_data[c]);
      tick();
    end
    check("rot_wc", word_count, 8);
    check("rot_idle", active, 0);

    load(2, 6'h30);
    load(2, 6'h31);
    load(2, 6'h32);
    #1;
    for (int c = 0; c < 8; c++) begin
      check("sp_pop", pop, sp_pop[c]);
      check("sp_push", push, sp_push[c]);
      if (sp_push[c]) check("sp_data", data_out, sp_data[c]);
      tick();
    end
    check("sp_wc", word_count, 11);

    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 3; n++) load(i, 6'(8 * i + n));
    for (int c = 0; c < 8; c++) begin
      pausa = bp_pausa[c];
      #1;
      check("bp_pop", pop, bp_pop[c]);
      check("bp_push", push, bp_push[c]);
      if (bp_push[c]) check("bp_data", data_out, bp_data[c]);
      tick();
    end
    check("bp_active", active, 1);

    #2;
    reset_L = 1'b0;
    #1;
    check("mid_rst_push", push, 0);
    check("mid_rst_pop", pop, 0);
    check("mid_rst_wc", word_count, 0);
    check("mid_rst_active", active, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 70; n++) load(i, 6'(n));
    reset_L = 1'b1;
    #1;
    check("grant_after_rst", pop, 4'b0001);

    cnt = 0;
    for (int k = 0; k < 400 && cnt < 259; k++) begin
      check("wc_track", word_count, 32'(cnt[7:0]));
      if (cnt == 256) check("wrap_zero", word_count, 0);
      if (push) cnt++;
      tick();
    end
    check("wrap_reached", 32'(cnt >= 259), 1);
    check("wrap_wc", word_count, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
